upsample_2x_array: RTL
======================

# upsample_2x_array

Nearest-neighbour 2x upsampler for the YOLOv3-tiny feature-map path; the structural inverse of the 2:1 max-pool lane array. It accepts one packed word of NUM_MODULES pixels per input handshake, where each lane is DATA_WIDTH*2 bits. It emits each pixel twice horizontally across two output words, then replays the whole buffered row once more for vertical duplication. It sits between a conv/pool result stream and the next layer's input buffer, using valid/ready on both sides.

## Interface
- DATA_WIDTH, 8, half-lane width; lane = DATA_WIDTH*2 bits
- NUM_MODULES, 16, lanes per word; must be even
- ROW_WORDS, 4, input words per feature-map row; line-buffer depth; ≥1
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  DATA_WIDTH*2*NUM_MODULES  input pixel word, lane i at bits [i*DATA_WIDTH*2 +: DATA_WIDTH*2]
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  DATA_WIDTH*2*NUM_MODULES  expanded pixel word, same lane packing
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_row_last  output  1  qualifies the last output word of each output row (valid only with out_valid)

## Operation
- States:
  - ACCEPT: in_ready=1, out_valid=0.
  - EMIT_LO, EMIT_HI: out_valid=1, in_ready=0.
- Flag pass: 0 = first emission of the row, 1 = replay.
- Word counter wcnt: 0..ROW_WORDS-1.
- Held register hold: one input word.
- ACCEPT with in_valid:
  - hold ← in_data.
  - linebuf[wcnt] ← in_data.
  - → EMIT_LO.
- EMIT_LO expansion: out lane 2j and 2j+1 = hold lane j, for j = 0..NUM_MODULES/2-1.
- EMIT_HI expansion: out lane 2j and 2j+1 = hold lane NUM_MODULES/2+j.
- EMIT_LO with out_ready → EMIT_HI.
- EMIT_HI with out_ready:
  - wcnt < ROW_WORDS-1 and pass=0: wcnt+1, → ACCEPT.
  - wcnt < ROW_WORDS-1 and pass=1: wcnt+1, hold ← linebuf[wcnt+1], → EMIT_LO.
  - wcnt = ROW_WORDS-1 and pass=0: pass ← 1, wcnt ← 0, hold ← linebuf[0], → EMIT_LO.
  - wcnt = ROW_WORDS-1 and pass=1: pass ← 0, wcnt ← 0, → ACCEPT.
- ROW_WORDS=1 edge case: the write of linebuf[0] and the hold load are coherent, because replay reads from linebuf, which was written at accept.
- out_row_last = (state==EMIT_HI) && (wcnt==ROW_WORDS-1).
- Backpressure: out_ready low holds the state, out_data and out_row_last stable.
- Pixel values are copied bit-exact; no arithmetic, no saturation.

## Timing
- Reset values (asynchronous, immediate):
  - state=ACCEPT, pass=0, wcnt=0, hold=0.
  - in_ready=1, out_valid=0, out_data=0, out_row_last=0.
  - linebuf is not reset.
- Reset mid-operation: any partial row is discarded; the first word after reset starts a new row at wcnt=0.
- Latency: word accepted at edge t → out_valid high in cycle t+1 (registered outputs).
- Throughput:
  - First pass: 3 cycles per input word (ACCEPT, EMIT_LO, EMIT_HI) with out_ready held high.
  - Replay: 2 cycles per word.
  - Full row: 5*ROW_WORDS cycles minimum.
- in_valid during EMIT_*: ignored, not accepted; the upstream holds its word.
- out_valid never drops without a handshake.

## Structure
- Package upsample_pkg holds:
  - state enum {ACCEPT, EMIT_LO, EMIT_HI}
  - LANE_W = DATA_WIDTH*2
  - the wcnt width function, $clog2(ROW_WORDS) with a minimum of 1
- Sub-module upsample_lane_expand: combinational; takes a word and a half select, produces the duplicated word.
  - Generate loop over NUM_MODULES/2, matching the lane-array style used for pooling.
- Line buffer: inferred register array inside the top; no separate memory module.

## Test plan
- Reset then idle, checked after rst=1 → 0:
  - in_ready=1, out_valid=0, out_data=0.
- ROW_WORDS=1, single word, lanes = 1..16, out_ready=1:
  - Outputs: {1,1,2,2,…,8,8}, {9,9,…,16,16}, then the same two words again.
  - out_row_last on outputs 2 and 4.
  - Then in_ready=1.
- ROW_WORDS=4, words A,B,C,D streamed:
  - 16 outputs: A_lo,A_hi,…,D_hi, then A_lo…D_hi.
  - out_row_last only on outputs 8 and 16.
- Backpressure: out_ready toggled 0/1 every cycle, and held low for 5 cycles mid-replay:
  - Output sequence is identical to the unstalled run.
  - out_data is stable while out_valid && !out_ready.
- in_valid held high continuously: words accepted only in ACCEPT cycles; no word is lost or duplicated, checked by scoreboard.
- Reset asserted during replay of word 2: outputs clear asynchronously; the next accepted word emits at wcnt=0 with pass=0.

Source files
------------

// File: rtl/upsample_pkg.sv
// Shared types and sizing helpers for the 2x nearest-neighbour upsampler.
package upsample_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int LANE_W         = DEF_DATA_WIDTH * 2;

  typedef enum logic [1:0] {ACCEPT, EMIT_LO, EMIT_HI} state_t;

  // Word-counter width; a one-word row still needs a 1-bit counter.
  function automatic int wcnt_w(input int row_words);
    return (row_words > 1) ? $clog2(row_words) : 1;
  endfunction
endpackage

// File: rtl/upsample_2x_array_if.sv
// Input and output valid/ready streams of the upsampler.
interface upsample_2x_array_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_MODULES = 16
);
  localparam int W = DATA_WIDTH * 2 * NUM_MODULES;

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_row_last;

  modport master (output in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_valid, out_row_last);
  modport slave  (input  in_data, in_valid, out_ready,
                  output in_ready, out_data, out_valid, out_row_last);
endinterface

// File: rtl/upsample_lane_expand.sv
// Combinational horizontal duplication: selected half of the word, each lane written twice.
module upsample_lane_expand
  import upsample_pkg::*;
#(
  parameter int LANE_W      = upsample_pkg::LANE_W,
  parameter int NUM_MODULES = 16
) (
  input  logic [NUM_MODULES-1:0][LANE_W-1:0] word,
  input  logic                               sel_hi,
  output logic [NUM_MODULES-1:0][LANE_W-1:0] dup
);
  localparam int HALF = NUM_MODULES / 2;

  for (genvar j = 0; j < HALF; j++) begin : g_lane
    logic [LANE_W-1:0] px;
    assign px         = sel_hi ? word[HALF+j] : word[j];
    assign dup[2*j]   = px;
    assign dup[2*j+1] = px;
  end
endmodule

// File: rtl/upsample_2x_array.sv
// 2x nearest-neighbour upsampler: each word emitted as two expanded words, then the
// buffered row is replayed once for vertical duplication.
module upsample_2x_array
  import upsample_pkg::*;
#(
  parameter int DATA_WIDTH  = upsample_pkg::DEF_DATA_WIDTH,
  parameter int NUM_MODULES = 16,
  parameter int ROW_WORDS   = 4
) (
  input logic              clk,
  input logic              rst,
  upsample_2x_array_if.slave bus
);
  localparam int              LW   = DATA_WIDTH * 2;
  localparam int              W    = LW * NUM_MODULES;
  localparam int              CW   = wcnt_w(ROW_WORDS);
  localparam logic [CW-1:0]   LAST = CW'(ROW_WORDS - 1);

  state_t          state, state_n;
  logic            pass, pass_n;
  logic [CW-1:0]   wcnt, wcnt_n, wcnt_inc;
  logic [W-1:0]    hold, hold_n;
  logic            buf_we;
  logic [W-1:0]    linebuf [ROW_WORDS];
  logic [W-1:0]    dup;

  assign wcnt_inc = wcnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCEPT;
      pass  <= 1'b0;
      wcnt  <= '0;
      hold  <= '0;
    end else begin
      state <= state_n;
      pass  <= pass_n;
      wcnt  <= wcnt_n;
      hold  <= hold_n;
    end
  end

  // Row storage is only read after it has been written this row, so it needs no reset.
  always_ff @(posedge clk) begin
    if (buf_we) linebuf[wcnt] <= bus.in_data;
  end

  always_comb begin
    state_n = state;
    pass_n  = pass;
    wcnt_n  = wcnt;
    hold_n  = hold;
    buf_we  = 1'b0;
    case (state)
      ACCEPT: begin
        if (bus.in_valid) begin
          hold_n  = bus.in_data;
          buf_we  = 1'b1;
          state_n = EMIT_LO;
        end
      end
      EMIT_LO: begin
        if (bus.out_ready) state_n = EMIT_HI;
      end
      EMIT_HI: begin
        if (bus.out_ready) begin
          if (wcnt != LAST) begin
            wcnt_n = wcnt_inc;
            if (pass) begin
              hold_n  = linebuf[wcnt_inc];
              state_n = EMIT_LO;
            end else begin
              state_n = ACCEPT;
            end
          end else begin
            wcnt_n = '0;
            if (!pass) begin
              pass_n  = 1'b1;
              hold_n  = linebuf[0];
              state_n = EMIT_LO;
            end else begin
              pass_n  = 1'b0;
              state_n = ACCEPT;
            end
          end
        end
      end
      default: state_n = ACCEPT;
    endcase
  end

  upsample_lane_expand #(
    .LANE_W      (LW),
    .NUM_MODULES (NUM_MODULES)
  ) u_expand (
    .word   (hold),
    .sel_hi (state == EMIT_HI),
    .dup    (dup)
  );

  assign bus.in_ready     = (state == ACCEPT);
  assign bus.out_valid    = (state != ACCEPT);
  assign bus.out_data     = (state == ACCEPT) ? '0 : dup;
  assign bus.out_row_last = (state == EMIT_HI) && (wcnt == LAST);
endmodule
